// File: rtl/enc_pkg.sv
// enc_pkg: op codes, RV32I field constants and the op-to-word encoder for inst_pair_encoder.
package enc_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_OR   = 4'd3,
        OP_AND  = 4'd4,
        OP_ADDI = 4'd5,
        OP_ORI  = 4'd6,
        OP_ANDI = 4'd7,
        OP_LW   = 4'd8,
        OP_SW   = 4'd9
    } op_e;

    typedef enum logic {EMPTY, HALF} pair_state_e;

    localparam logic [6:0]  OPC_OP    = 7'b0110011;
    localparam logic [6:0]  OPC_IMM   = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPC_STORE = 7'b0100011;
    localparam logic [2:0]  F3_ADD    = 3'b000;
    localparam logic [2:0]  F3_OR     = 3'b110;
    localparam logic [2:0]  F3_AND    = 3'b111;
    localparam logic [2:0]  F3_W      = 3'b010;
    localparam logic [6:0]  F7_BASE   = 7'b0000000;
    localparam logic [6:0]  F7_SUB    = 7'b0100000;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [3:0]  OP_LAST   = 4'd9;

    // Unused fields never reach the word; reserved codes fall through to NOP.
    function automatic logic [31:0] encode(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [11:0] imm);
        logic [31:0] w;
        w = NOP_WORD;
        case (op)
            OP_ADD:  w = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_SUB:  w = {F7_SUB, rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_OR:   w = {F7_BASE, rs2, rs1, F3_OR, rd, OPC_OP};
            OP_AND:  w = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_OP};
            OP_ADDI: w = {imm, rs1, F3_ADD, rd, OPC_IMM};
            OP_ORI:  w = {imm, rs1, F3_OR, rd, OPC_IMM};
            OP_ANDI: w = {imm, rs1, F3_AND, rd, OPC_IMM};
            OP_LW:   w = {imm, rs1, F3_W, rd, OPC_LOAD};
            OP_SW:   w = {imm[11:5], rs2, rs1, F3_W, imm[4:0], OPC_STORE};
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// pair_fifo: synchronous FIFO of 64-bit instruction pairs; head reads as zero while empty.
module pair_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic [63:0]                 push_data,
    input  logic                        pop,
    output logic [63:0]                 pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full     = count == CW'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? 64'h0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_pair_encoder.sv
// inst_pair_encoder: RV32I op encoder, pairing FSM and pair FIFO for the dual-issue front end.
// ENC_ILLEGAL_CHK_EN: drop reserved ops and pulse err instead of encoding them as NOP.
module inst_pair_encoder
    import enc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  in_op,
    input  logic [4:0]                  in_rd,
    input  logic [4:0]                  in_rs1,
    input  logic [4:0]                  in_rs2,
    input  logic [11:0]                 in_imm,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_inst1,
    output logic [31:0]                 out_inst2,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        pending,
    output logic                        err
);
    pair_state_e state;
    logic [31:0] hold, word;
    logic        full, empty, drop, accept, push, pop;

    assign word = encode(op_e'(in_op), in_rd, in_rs1, in_rs2, in_imm);

`ifdef ENC_ILLEGAL_CHK_EN
    assign drop = in_op > OP_LAST;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err <= 1'b0;
        else err <= in_valid && in_ready && drop;
    end
`else
    assign drop = 1'b0;
    assign err  = 1'b0;
`endif

    assign pending   = state == HALF;
    assign in_ready  = !flush && (!pending || !full);
    assign accept    = in_valid && in_ready && !drop;
    // A flush only ever pushes when no op is accepted, so the pad slot is selected by !accept.
    assign push      = pending && (accept || (flush && !full));
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
            hold  <= NOP_WORD;
        end else if (state == EMPTY && accept) begin
            state <= HALF;
            hold  <= word;
        end else if (push) begin
            state <= EMPTY;
        end
    end

    pair_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({hold, accept ? word : NOP_WORD}),
        .pop       (pop),
        .pop_data  ({out_inst1, out_inst2}),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_inst_pair_encoder.sv
// tb_inst_pair_encoder: directed and random stimulus against a queue-based pairing model.
module tb_inst_pair_encoder;
    localparam int DEPTH = 4;
`ifdef ENC_ILLEGAL_CHK_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_ready, flush, out_valid, out_ready, pending, err;
    logic [3:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [11:0] in_imm;
    logic [31:0] out_inst1, out_inst2;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    logic [63:0] q[$];
    bit          m_pend;
    logic [31:0] m_hold;
    bit          m_err;

    always #5 clk = ~clk;

    inst_pair_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst1(out_inst1), .out_inst2(out_inst2),
        .count(count), .pending(pending), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_enc(int unsigned op, int unsigned rd, int unsigned rs1,
                                            int unsigned rs2, int unsigned imm);
        int unsigned f3[10] = '{0, 0, 0, 6, 7, 0, 6, 7, 2, 2};
        int unsigned r;
        r = imm & 32'hfff;
        if (op >= 1 && op <= 4)
            return 32'((((op == 2) ? 32 : 0) << 25) | (rs2 << 20) | (rs1 << 15) | (f3[op] << 12) | (rd << 7) | 'h33);
        if (op >= 5 && op <= 7)
            return 32'((r << 20) | (rs1 << 15) | (f3[op] << 12) | (rd << 7) | 'h13);
        if (op == 8)
            return 32'((r << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03);
        if (op == 9)
            return 32'(((r >> 5) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | ((r & 31) << 7) | 'h23);
        return 32'h0;
    endfunction

    task automatic check_outputs(input bit rdy);
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("count", 64'(count), 64'(q.size()));
        check("pending", 64'(pending), 64'(m_pend));
        check("err", 64'(err), 64'(m_err));
        check("head", {out_inst1, out_inst2}, q.size() != 0 ? q[0] : 64'h0);
    endtask

    task automatic cycle(input bit v, input int unsigned op, input int unsigned rd, input int unsigned rs1,
                         input int unsigned rs2, input int unsigned imm, input bit fl, input bit ordy);
        logic [31:0] w;
        logic [63:0] pr;
        bit rdy, acc, drop, pop, psh;
        @(negedge clk);
        in_valid = v; in_op = 4'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        in_imm = 12'(imm); flush = fl; out_ready = ordy;
        #1;
        rdy = !fl && (!m_pend || q.size() < DEPTH);
        check_outputs(rdy);
        drop = ILL && op >= 10;
        acc  = v && rdy && !drop;
        w    = ref_enc(op, rd, rs1, rs2, imm);
        pop  = q.size() != 0 && ordy;
        psh  = m_pend && (acc || (fl && q.size() < DEPTH));
        pr   = {m_hold, acc ? w : 32'h0};
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (psh) begin
            q.push_back(pr);
            m_pend = 1'b0;
        end else if (acc) begin
            m_hold = w;
            m_pend = 1'b1;
        end
        m_err = v && rdy && drop;
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 0, 0, 0, 0, 0, 1'b0, ordy);
    endtask

    task automatic model_reset();
        q.delete();
        m_pend = 1'b0;
        m_hold = 32'h0;
        m_err  = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_insts"}, {out_inst1, out_inst2}, 64'h0);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_pending"}, 64'(pending), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("rst");
        reset_n = 1'b1;

        cycle(1'b1, 1, 3, 1, 2, 0, 1'b0, 1'b0);
        cycle(1'b1, 2, 5, 6, 7, 0, 1'b0, 1'b0);
        #1;
        check("tp_add_sub", {out_inst1, out_inst2}, 64'h002081B3_407302B3);
        check("tp_add_sub_count", 64'(count), 64'd1);

        cycle(1'b1, 8, 4, 2, 0, 8, 1'b0, 1'b1);
        cycle(1'b1, 9, 0, 2, 5, 12, 1'b0, 1'b0);
        #1;
        check("tp_lw_sw", {out_inst1, out_inst2}, 64'h00812203_00512623);
        idle(1'b1);
        idle(1'b1);

        cycle(1'b1, 7, 1, 1, 0, 'hFF, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        #1;
        check("tp_flush_pair", {out_inst1, out_inst2}, 64'h0FF0F093_00000000);
        check("tp_flush_pending", 64'(pending), 64'd0);
        idle(1'b1);
        cycle(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

        for (int i = 0; i < 9; i++) cycle(1'b1, 1 + i % 9, i, i + 1, i + 2, i * 3, 1'b0, 1'b0);
        #1;
        check("tp_full_count", 64'(count), 64'd4);
        check("tp_full_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 5, 9, 9, 9, 99, 1'b0, 1'b1);
        cycle(1'b1, 5, 9, 9, 9, 99, 1'b0, 1'b0);
        #1;
        check("tp_fifth_pair_count", 64'(count), 64'd4);
        check("tp_fifth_pending", 64'(pending), 64'd0);
        repeat (5) idle(1'b1);

        cycle(1'b1, 1, 3, 1, 2, 0, 1'b0, 1'b0);
        cycle(1'b1, 12, 7, 7, 7, 7, 1'b0, 1'b0);
        cycle(1'b1, 15, 1, 1, 1, 1, 1'b0, 1'b0);
        cycle(1'b1, 2, 5, 6, 7, 0, 1'b0, 1'b0);
        repeat (4) idle(1'b1);

        for (int i = 0; i < 5; i++) cycle(1'b1, 1, 1, 2, 3, 0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        check("tp_pre_rst_count", 64'(count), 64'd2);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset("async_rst");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 4095),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
        repeat (6) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
